// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_pkg
// Brief    : Shared types and constants for the multi-channel PWM core.
// Revision : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    typedef enum logic {
        PWM_MODE_EDGE   = 1'b0,
        PWM_MODE_CENTER = 1'b1
    } pwm_mode_e;

    localparam logic PWM_DIR_UP   = 1'b0;
    localparam logic PWM_DIR_DOWN = 1'b1;

endpackage
`default_nettype wire

// File: rtl/pwm_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : pwm_prescaler
// Brief    : Free-running prescale counter emitting one tick every pscr_i+1 clocks.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_prescaler
    import pwm_pkg::*;
#(
    parameter int PSCR_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic [PSCR_WIDTH-1:0] pscr_i,
    output logic                  tick_o
);

    logic [PSCR_WIDTH-1:0] r_pcnt;
    logic                  w_wrap;

    assign w_wrap = (r_pcnt == pscr_i);
    assign tick_o = en_i && w_wrap;

    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i || w_wrap) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= r_pcnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pwm_multi_core.sv
`default_nettype none
// ============================================================================
// Module   : pwm_multi_core
// Brief    : Multi-channel PWM timer, edge/center aligned, double-buffered config.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_multi_core
    import pwm_pkg::*;
#(
    parameter int CHN_NUM    = 4,
    parameter int CNT_WIDTH  = 16,
    parameter int PSCR_WIDTH = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         en_i,
    input  logic                         mode_i,
    input  logic [PSCR_WIDTH-1:0]        pscr_i,
    input  logic [CNT_WIDTH-1:0]         cmp_i,
    input  logic [CHN_NUM*CNT_WIDTH-1:0] crx_i,
    input  logic [CHN_NUM-1:0]           pol_i,
    input  logic                         upd_i,
    output logic                         upd_pend_o,
    output logic [CNT_WIDTH-1:0]         cnt_o,
    output logic                         dir_o,
    output logic [CHN_NUM-1:0]           pwm_o,
    output logic                         ov_o
);

    pwm_mode_e                    r_mode_s;
    logic [PSCR_WIDTH-1:0]        r_pscr_s;
    logic [CNT_WIDTH-1:0]         r_cmp_s;
    logic [CHN_NUM*CNT_WIDTH-1:0] r_crx_s;
    logic [CHN_NUM-1:0]           r_pol_s;

    logic                 r_dir;
    logic                 w_dir_nxt;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;

    logic               w_tick;
    logic               w_bnd;
    logic               w_load;
    logic               r_upd_pend;
    logic               r_ov;
    logic               r_en_d;
    logic [CHN_NUM-1:0] w_raw;
    logic [CHN_NUM-1:0] r_pwm;

    pwm_prescaler #(
        .PSCR_WIDTH (PSCR_WIDTH)
    ) u_prescaler (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (en_i),
        .pscr_i (r_pscr_s),
        .tick_o (w_tick)
    );

    // Idle keeps the shadows transparent; while running they only move at a boundary.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mode_s <= PWM_MODE_EDGE;
            r_pscr_s <= '0;
            r_cmp_s  <= '0;
            r_crx_s  <= '0;
            r_pol_s  <= '0;
        end else if (w_load) begin
            r_mode_s <= pwm_mode_e'(mode_i);
            r_pscr_s <= pscr_i;
            r_cmp_s  <= cmp_i;
            r_crx_s  <= crx_i;
            r_pol_s  <= pol_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i) begin
            r_cnt <= '0;
            r_dir <= PWM_DIR_UP;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_dir <= w_dir_nxt;
        end
    end

    always_comb begin
        w_cnt_nxt = r_cnt;
        w_dir_nxt = r_dir;
        if (w_tick) begin
            if (r_mode_s == PWM_MODE_EDGE) begin
                w_dir_nxt = PWM_DIR_UP;
                w_cnt_nxt = (r_cnt >= r_cmp_s) ? '0 : r_cnt + 1'b1;
            end else if (r_cmp_s == '0) begin
                w_dir_nxt = PWM_DIR_UP;
                w_cnt_nxt = '0;
            end else begin
                case (r_dir)
                    PWM_DIR_UP: begin
                        if (r_cnt >= r_cmp_s) begin
                            w_dir_nxt = PWM_DIR_DOWN;
                            w_cnt_nxt = r_cnt - 1'b1;
                        end else begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end
                    default: begin
                        if (r_cnt == '0) begin
                            w_dir_nxt = PWM_DIR_UP;
                            w_cnt_nxt = r_cnt + 1'b1;
                        end else begin
                            w_cnt_nxt = r_cnt - 1'b1;
                        end
                    end
                endcase
            end
        end
        // Switching mode mid-descent would leave edge mode counting the wrong way.
        if (w_load && (r_mode_s != pwm_mode_e'(mode_i))) begin
            w_dir_nxt = PWM_DIR_UP;
        end
    end

    always_comb begin
        w_bnd = 1'b0;
        if (w_tick) begin
            if (r_mode_s == PWM_MODE_EDGE) begin
                w_bnd = (r_cnt >= r_cmp_s);
            end else begin
                w_bnd = (r_cmp_s == '0) || ((r_dir == PWM_DIR_DOWN) && (r_cnt == '0));
            end
        end
        w_load = !en_i || (w_bnd && (r_upd_pend || upd_i));
    end

    for (genvar gi = 0; gi < CHN_NUM; gi++) begin : g_chan
        assign w_raw[gi] = (r_cnt < r_crx_s[gi*CNT_WIDTH +: CNT_WIDTH]);
    end

    // r_en_d holds the outputs live for one extra cycle so the last count is still shown.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_upd_pend <= 1'b0;
            r_ov       <= 1'b0;
            r_en_d     <= 1'b0;
            r_pwm      <= '0;
        end else begin
            r_en_d <= en_i;
            r_ov   <= en_i && w_bnd;
            if (!en_i || (w_bnd && (r_upd_pend || upd_i))) begin
                r_upd_pend <= 1'b0;
            end else if (upd_i) begin
                r_upd_pend <= 1'b1;
            end
            r_pwm <= (en_i || r_en_d) ? (w_raw ^ r_pol_s) : r_pol_s;
        end
    end

    assign upd_pend_o = r_upd_pend;
    assign cnt_o      = r_cnt;
    assign dir_o      = r_dir;
    assign pwm_o      = r_pwm;
    assign ov_o       = r_ov;

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_multi_core
// Brief    : Self-checking bench for pwm_multi_core against a phase-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_multi_core;

    localparam int CH = 4;
    localparam int CW = 16;
    localparam int PW = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic           mode;
    logic [PW-1:0]  pscr;
    logic [CW-1:0]  cmp;
    logic [CH*CW-1:0] crx;
    logic [CH-1:0]  pol;
    logic           upd;
    logic           upd_pend;
    logic [CW-1:0]  cnt;
    logic           dir;
    logic [CH-1:0]  pwm;
    logic           ov;

    pwm_multi_core #(
        .CHN_NUM    (CH),
        .CNT_WIDTH  (CW),
        .PSCR_WIDTH (PW)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .en_i       (en),
        .mode_i     (mode),
        .pscr_i     (pscr),
        .cmp_i      (cmp),
        .crx_i      (crx),
        .pol_i      (pol),
        .upd_i      (upd),
        .upd_pend_o (upd_pend),
        .cnt_o      (cnt),
        .dir_o      (dir),
        .pwm_o      (pwm),
        .ov_o       (ov)
    );

    always #5 clk = ~clk;

    // Model: position within the period (ph) plus a flag for "fresh start at 0, going up".
    int          m_mode, m_pscr, m_cmp, m_ph, m_pc;
    int          m_crx [CH];
    logic [CH-1:0] m_pol, m_pwm;
    bit          m_fresh, m_pend, m_ov, m_en_d;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        mode;
        int          pscr;
        int          cmp;
        logic [63:0] crx;
        logic [3:0]  pol;
        int          per;
        logic [31:0] hi;
    } vec_t;

    vec_t tbl [8];
    int   exp_c [10];
    int   exp_d [10];
    int   exp_o [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int cnt_of();
        if (m_mode == 0) return m_ph;
        if (m_ph <= m_cmp) return m_ph;
        return 2 * m_cmp - m_ph;
    endfunction

    function automatic int dir_of();
        if (m_mode == 0) return 0;
        return ((m_ph > m_cmp) || (m_ph == 0 && !m_fresh)) ? 1 : 0;
    endfunction

    task automatic load_shadows();
        if (m_mode != int'(mode)) m_fresh = 1;
        m_mode = int'(mode);
        m_pscr = int'(pscr);
        m_cmp  = int'(cmp);
        for (int i = 0; i < CH; i++) m_crx[i] = int'(crx[i*CW +: CW]);
        m_pol = pol;
    endtask

    task automatic model_edge();
        int         oc;
        bit         bnd;
        logic [CH-1:0] raw;
        if (rst) begin
            m_mode = 0; m_pscr = 0; m_cmp = 0; m_pol = '0;
            for (int i = 0; i < CH; i++) m_crx[i] = 0;
            m_ph = 0; m_pc = 0; m_fresh = 1; m_pend = 0; m_ov = 0; m_en_d = 0; m_pwm = '0;
            return;
        end
        oc = cnt_of();
        for (int i = 0; i < CH; i++) raw[i] = (oc < m_crx[i]);
        m_pwm  = (en || m_en_d) ? (raw ^ m_pol) : m_pol;
        m_en_d = en;
        if (!en) begin
            load_shadows();
            m_ph = 0; m_fresh = 1; m_pc = 0; m_pend = 0; m_ov = 0;
        end else begin
            bnd = 0;
            if (m_pc == m_pscr) begin
                m_pc = 0;
                if (m_mode == 0) begin
                    if (m_ph >= m_cmp) begin bnd = 1; m_ph = 0; end
                    else m_ph++;
                end else if (m_cmp == 0) begin
                    bnd = 1; m_ph = 0; m_fresh = 1;
                end else if (m_ph == 0 && !m_fresh) begin
                    bnd = 1; m_ph = 1;
                end else begin
                    m_ph = (m_ph + 1) % (2 * m_cmp);
                    m_fresh = 0;
                end
            end else begin
                m_pc++;
            end
            m_ov = bnd;
            if (bnd && (m_pend || upd)) begin
                load_shadows();
                m_pend = 0;
            end else if (upd) begin
                m_pend = 1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("cnt_o", cnt, cnt_of());
        check("dir_o", dir, dir_of());
        check("pwm_o", pwm, m_pwm);
        check("ov_o", ov, m_ov);
        check("upd_pend_o", upd_pend, m_pend);
    endtask

    task automatic wait_ov(output bit ok);
        ok = 0;
        for (int k = 0; k < 400 && !ok; k++) begin
            step();
            if (ov) ok = 1;
        end
        check("wait_ov_bound", ok, 1);
    endtask

    task automatic wait_cnt(input int v);
        bit ok;
        ok = 0;
        for (int k = 0; k < 400 && !ok; k++) begin
            if (int'(cnt) == v) ok = 1;
            else step();
        end
        check("wait_cnt_bound", ok, 1);
    endtask

    task automatic from_ov(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!ov && n < 400);
    endtask

    task automatic idle_cfg(input logic md, input int ps, input int cp,
                            input logic [63:0] cr, input logic [3:0] pl);
        en = 0; mode = md; pscr = PW'(ps); cmp = CW'(cp); crx = cr; pol = pl;
        step();
        step();
        en = 1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        bit ok;
        int n;
        int h [CH];
        idle_cfg(v.mode, v.pscr, v.cmp, v.crx, v.pol);
        wait_ov(ok);
        n = 0;
        for (int i = 0; i < CH; i++) h[i] = 0;
        if (ok) begin
            do begin
                for (int i = 0; i < CH; i++) h[i] += int'(pwm[i]);
                n++;
                step();
            end while (!ov && n < 400);
        end
        check($sformatf("vec%0d_period", idx), n, v.per);
        for (int i = 0; i < CH; i++)
            check($sformatf("vec%0d_high_ch%0d", idx, i), h[i], v.hi[i*8 +: 8]);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int n;
        int nov;

        rst = 1; en = 0; mode = 0; pscr = '0; cmp = '0; crx = '0; pol = '0; upd = 0;

        tbl[0] = '{1'b0, 0, 9, {16'd5, 16'd10, 16'd0, 16'd3}, 4'b0000, 10, {8'd5, 8'd10, 8'd0, 8'd3}};
        tbl[1] = '{1'b0, 3, 4, {16'd5, 16'd0, 16'd4, 16'd2}, 4'b0000, 20, {8'd20, 8'd0, 8'd16, 8'd8}};
        tbl[2] = '{1'b1, 0, 4, {16'd5, 16'd4, 16'd1, 16'd2}, 4'b0000, 8, {8'd8, 8'd7, 8'd1, 8'd3}};
        tbl[3] = '{1'b0, 0, 5, {16'd6, 16'd0, 16'd1, 16'd4}, 4'b0101, 6, {8'd6, 8'd6, 8'd1, 8'd2}};
        tbl[4] = '{1'b1, 1, 3, {16'd3, 16'd0, 16'd2, 16'd1}, 4'b0000, 12, {8'd10, 8'd0, 8'd6, 8'd2}};
        tbl[5] = '{1'b1, 0, 0, {16'd0, 16'd1, 16'd0, 16'd1}, 4'b1000, 1, {8'd1, 8'd1, 8'd0, 8'd1}};
        tbl[6] = '{1'b0, 0, 0, {16'd0, 16'd0, 16'd2, 16'd1}, 4'b0000, 1, {8'd0, 8'd0, 8'd1, 8'd1}};
        tbl[7] = '{1'b1, 2, 1, {16'd2, 16'd1, 16'd0, 16'd1}, 4'b0000, 6, {8'd6, 8'd3, 8'd0, 8'd3}};

        exp_c = '{1, 2, 3, 4, 3, 2, 1, 0, 1, 2};
        exp_d = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
        exp_o = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};

        step();
        step();
        check("reset_cnt", cnt, 0);
        check("reset_dir", dir, 0);
        check("reset_pwm", pwm, 0);
        check("reset_ov", ov, 0);
        check("reset_pend", upd_pend, 0);
        rst = 0;

        foreach (tbl[i]) run_vec(tbl[i], i);

        // Center-aligned count and direction sequence from enable.
        idle_cfg(1'b1, 0, 4, 64'd2, 4'b0000);
        for (int i = 0; i < 10; i++) begin
            step();
            check("center_cnt", cnt, exp_c[i]);
            check("center_dir", dir, exp_d[i]);
            check("center_ov", ov, exp_o[i]);
        end

        // First tick lands pscr+1 clocks after enable.
        idle_cfg(1'b0, 3, 4, 64'd0, 4'b0000);
        for (int i = 0; i < 8; i++) begin
            step();
            check("pscr_cnt", cnt, (i + 1) / 4);
        end

        // Shadow update: held off without upd, applied at boundary after upd.
        idle_cfg(1'b0, 0, 9, 64'd3, 4'b0000);
        cmp = 16'd4;
        wait_ov(ok);
        from_ov(n);
        check("no_upd_period", n, 10);
        wait_cnt(5);
        upd = 1;
        step();
        upd = 0;
        check("upd_pend_set", upd_pend, 1);
        wait_ov(ok);
        check("upd_pend_clear", upd_pend, 0);
        from_ov(n);
        check("upd_new_period", n, 5);
        cmp = 16'd7;
        wait_cnt(4);
        upd = 1;
        step();
        upd = 0;
        check("upd_on_bnd_ov", ov, 1);
        check("upd_on_bnd_pend", upd_pend, 0);
        check("upd_on_bnd_cnt", cnt, 0);
        from_ov(n);
        check("upd_on_bnd_period", n, 8);

        // Polarity and disable.
        idle_cfg(1'b0, 0, 9, 64'd3, 4'b0001);
        wait_cnt(1);
        check("pol_inv_low", pwm[0], 0);
        wait_cnt(6);
        check("pol_inv_high", pwm[0], 1);
        en = 0;
        step();
        check("dis_cnt", cnt, 0);
        step();
        check("dis_pwm_inactive", pwm, 4'b0001);
        nov = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            nov += int'(ov);
        end
        check("dis_no_ov", nov, 0);

        // Reset mid-run with an update pending.
        idle_cfg(1'b0, 0, 9, {16'd4, 16'd8, 16'd2, 16'd6}, 4'b1010);
        for (int i = 0; i < 4; i++) step();
        upd = 1;
        step();
        upd = 0;
        rst = 1;
        step();
        check("midrst_cnt", cnt, 0);
        check("midrst_pwm", pwm, 0);
        check("midrst_ov", ov, 0);
        check("midrst_pend", upd_pend, 0);
        step();
        rst = 0;
        for (int i = 0; i < 6; i++) step();

        // Randomized segments, checked every cycle against the model.
        for (int seg = 0; seg < 6; seg++) begin
            idle_cfg(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 12)),
                     {16'($urandom_range(0, 14)), 16'($urandom_range(0, 14)),
                      16'($urandom_range(0, 14)), 16'($urandom_range(0, 14))},
                     4'($urandom));
            for (int c = 0; c < 150; c++) begin
                if ($urandom_range(0, 9) == 0) begin
                    mode = 1'($urandom_range(0, 1));
                    pscr = PW'($urandom_range(0, 3));
                    cmp  = CW'($urandom_range(1, 12));
                    crx  = {16'($urandom_range(0, 14)), 16'($urandom_range(0, 14)),
                            16'($urandom_range(0, 14)), 16'($urandom_range(0, 14))};
                    pol  = 4'($urandom);
                end
                upd = ($urandom_range(0, 15) == 0);
                en  = ($urandom_range(0, 99) != 0);
                rst = ($urandom_range(0, 299) == 0);
                step();
            end
            upd = 0;
            rst = 0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
